// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: round-robin share of the register file write port plus per-register busy scoreboard
module rf_write_arbiter #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_data,
   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_data,
   input  logic                  rsv_valid,
   output logic                  rsv_ready,
   input  logic [ADDR_WIDTH-1:0] rsv_addr,
   input  logic [ADDR_WIDTH-1:0] qa_addr,
   input  logic [ADDR_WIDTH-1:0] qb_addr,
   output logic                  qa_busy,
   output logic                  qb_busy,
   output logic                  rf_w_en,
   output logic [ADDR_WIDTH-1:0] rf_waddr,
   output logic [DATA_WIDTH-1:0] rf_wdata
);
   localparam int NREG = 1 << ADDR_WIDTH;
   logic [NREG-1:0] busy, busy_nx;
   logic last_grant, g0, g1, w_en_nx;
   assign g0 = req0_valid && (!req1_valid || last_grant);
   assign g1 = req1_valid && !g0;
   assign req0_ready = g0;
   assign req1_ready = g1;
   assign rsv_ready = !busy[rsv_addr];
   assign qa_busy = busy[qa_addr];
   assign qb_busy = busy[qb_addr];
   assign w_en_nx = g0 ? (req0_addr != '0) : (g1 && req1_addr != '0);
   always_comb begin
      busy_nx = busy;
      if (rf_w_en) busy_nx[rf_waddr] = 1'b0;
      if (rsv_valid && rsv_ready) busy_nx[rsv_addr] = 1'b1;
      busy_nx[0] = 1'b0;
   end
   always_ff @(posedge clk) begin
      if (!rstn) begin
         busy       <= '0;
         rf_w_en    <= 1'b0;
         rf_waddr   <= '0;
         rf_wdata   <= '0;
         last_grant <= 1'b1;
      end else begin
         busy    <= busy_nx;
         rf_w_en <= w_en_nx;
         if (g0 || g1) begin
            rf_waddr   <= g0 ? req0_addr : req1_addr;
            rf_wdata   <= g0 ? req0_data : req1_data;
            last_grant <= g1;
         end
      end
   end
endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb_rf_write_arbiter: directed stimulus with a write scoreboard queue drained by a monitor
module tb_rf_write_arbiter;
   localparam int AW = 5;
   localparam int DW = 32;
   logic clk = 0, rstn = 0;
   logic req0_valid = 0, req1_valid = 0, rsv_valid = 0;
   logic [AW-1:0] req0_addr = '0, req1_addr = '0, rsv_addr = '0, qa_addr = '0, qb_addr = '0;
   logic [DW-1:0] req0_data = '0, req1_data = '0;
   logic req0_ready, req1_ready, rsv_ready, qa_busy, qb_busy, rf_w_en;
   logic [AW-1:0] rf_waddr;
   logic [DW-1:0] rf_wdata;
   logic [AW+DW-1:0] exp_q[$];
   logic mon_en = 0;
   int checks = 0, errors = 0;
   int g_tab[4] = '{0, 1, 0, 1};
   int a_tab[4] = '{1, 2, 1, 2};

   rf_write_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rstn(rstn),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr), .req0_data(req0_data),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr), .req1_data(req1_data),
      .rsv_valid(rsv_valid), .rsv_ready(rsv_ready), .rsv_addr(rsv_addr),
      .qa_addr(qa_addr), .qb_addr(qb_addr), .qa_busy(qa_busy), .qb_busy(qb_busy),
      .rf_w_en(rf_w_en), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", n, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (mon_en && rf_w_en) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL sb_unexpected got addr=%0d data=%h exp=none", rf_waddr, rf_wdata);
         end else begin
            logic [AW+DW-1:0] e;
            e = exp_q.pop_front();
            chk("sb_addr", 32'(rf_waddr), 32'(e[AW+DW-1:DW]));
            chk("sb_data", rf_wdata, e[DW-1:0]);
         end
      end
   end

   initial begin
      repeat (2) @(posedge clk);
      #1 rstn = 1;
      mon_en = 1;
      @(negedge clk);
      chk("rst_wen", 32'(rf_w_en), 0);
      chk("rst_waddr", 32'(rf_waddr), 0);
      chk("rst_wdata", rf_wdata, 0);
      chk("rst_rsv_ready", 32'(rsv_ready), 1);
      for (int a = 0; a < 32; a++) begin
         qa_addr = AW'(a);
         qb_addr = AW'(31 - a);
         #1;
         chk("rst_qa_busy", 32'(qa_busy), 0);
         chk("rst_qb_busy", 32'(qb_busy), 0);
      end
      // round-robin alternation from reset
      for (int i = 0; i < 4; i++) begin
         next_cycle();
         req0_valid = 1; req0_addr = 5'd1; req0_data = 32'h11;
         req1_valid = 1; req1_addr = 5'd2; req1_data = 32'h22;
         exp_q.push_back(g_tab[i] == 0 ? {5'd1, 32'h11} : {5'd2, 32'h22});
         @(negedge clk);
         chk("rr_ready0", 32'(req0_ready), 32'(g_tab[i] == 0));
         chk("rr_ready1", 32'(req1_ready), 32'(g_tab[i] == 1));
         if (i > 0) begin
            chk("rr_wen", 32'(rf_w_en), 1);
            chk("rr_waddr", 32'(rf_waddr), 32'(a_tab[i-1]));
         end
      end
      next_cycle();
      req0_valid = 0; req1_valid = 0;
      @(negedge clk);
      chk("rr_last_wen", 32'(rf_w_en), 1);
      chk("rr_last_waddr", 32'(rf_waddr), 2);
      // reserve x5, write it, watch busy clear at commit
      next_cycle();
      rsv_valid = 1; rsv_addr = 5'd5;
      @(negedge clk);
      chk("x5_rsv_ready", 32'(rsv_ready), 1);
      next_cycle();
      rsv_valid = 0; qa_addr = 5'd5;
      req0_valid = 1; req0_addr = 5'd5; req0_data = 32'hDEADBEEF;
      exp_q.push_back({5'd5, 32'hDEADBEEF});
      @(negedge clk);
      chk("x5_ready0", 32'(req0_ready), 1);
      chk("x5_ready1", 32'(req1_ready), 0);
      chk("x5_busy_issue", 32'(qa_busy), 1);
      next_cycle();
      req0_valid = 0;
      @(negedge clk);
      chk("x5_wen", 32'(rf_w_en), 1);
      chk("x5_waddr", 32'(rf_waddr), 5);
      chk("x5_wdata", rf_wdata, 32'hDEADBEEF);
      chk("x5_busy_commit", 32'(qa_busy), 1);
      next_cycle();
      @(negedge clk);
      chk("x5_busy_after", 32'(qa_busy), 0);
      chk("x5_wen_idle", 32'(rf_w_en), 0);
      // back-to-back reservation of x7 stalls until the write commits
      next_cycle();
      rsv_valid = 1; rsv_addr = 5'd7;
      @(negedge clk);
      chk("x7_rsv1", 32'(rsv_ready), 1);
      next_cycle();
      req1_valid = 1; req1_addr = 5'd7; req1_data = 32'h77;
      exp_q.push_back({5'd7, 32'h77});
      @(negedge clk);
      chk("x7_rsv2_stall", 32'(rsv_ready), 0);
      chk("x7_ready1", 32'(req1_ready), 1);
      next_cycle();
      req1_valid = 0;
      @(negedge clk);
      chk("x7_wen", 32'(rf_w_en), 1);
      chk("x7_waddr", 32'(rf_waddr), 7);
      chk("x7_rsv2_commit", 32'(rsv_ready), 0);
      next_cycle();
      @(negedge clk);
      chk("x7_rsv2_go", 32'(rsv_ready), 1);
      next_cycle();
      rsv_valid = 0; qa_addr = 5'd7; qb_addr = 5'd5;
      @(negedge clk);
      chk("x7_busy_again", 32'(qa_busy), 1);
      chk("x5_busy_qb", 32'(qb_busy), 0);
      next_cycle();
      req0_valid = 1; req0_addr = 5'd7; req0_data = 32'h700;
      exp_q.push_back({5'd7, 32'h700});
      @(negedge clk);
      chk("x7b_ready0", 32'(req0_ready), 1);
      next_cycle();
      req0_valid = 0;
      next_cycle();
      @(negedge clk);
      chk("x7_busy_clear", 32'(qa_busy), 0);
      // x0 writes and reservations are inert
      next_cycle();
      req1_valid = 1; req1_addr = 5'd0; req1_data = 32'hFFFFFFFF;
      @(negedge clk);
      chk("x0_ready1", 32'(req1_ready), 1);
      next_cycle();
      req1_valid = 0; rsv_valid = 1; rsv_addr = 5'd0; qa_addr = 5'd0;
      @(negedge clk);
      chk("x0_wen", 32'(rf_w_en), 0);
      chk("x0_rsv_ready", 32'(rsv_ready), 1);
      next_cycle();
      @(negedge clk);
      chk("x0_busy", 32'(qa_busy), 0);
      chk("x0_rsv_ready2", 32'(rsv_ready), 1);
      // reset mid-operation drops the in-flight write and restores req0 priority
      next_cycle();
      rsv_valid = 1; rsv_addr = 5'd3; qa_addr = 5'd3;
      next_cycle();
      rsv_valid = 0;
      req0_valid = 1; req0_addr = 5'd3; req0_data = 32'h33;
      @(negedge clk);
      chk("rst3_ready0", 32'(req0_ready), 1);
      chk("rst3_busy_pre", 32'(qa_busy), 1);
      rstn = 0;
      next_cycle();
      rstn = 1; req0_valid = 0;
      @(negedge clk);
      chk("rst3_wen", 32'(rf_w_en), 0);
      chk("rst3_busy", 32'(qa_busy), 0);
      next_cycle();
      req0_valid = 1; req0_addr = 5'd8; req0_data = 32'h88;
      req1_valid = 1; req1_addr = 5'd9; req1_data = 32'h99;
      exp_q.push_back({5'd8, 32'h88});
      @(negedge clk);
      chk("rst3_pair_ready0", 32'(req0_ready), 1);
      chk("rst3_pair_ready1", 32'(req1_ready), 0);
      next_cycle();
      exp_q.push_back({5'd9, 32'h99});
      @(negedge clk);
      chk("rst3_pair2_ready1", 32'(req1_ready), 1);
      next_cycle();
      req0_valid = 0; req1_valid = 0;
      repeat (3) next_cycle();
      chk("sb_drain", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/rf_write_arbiter.md
Name: rf_write_arbiter

Overview:
- Shares the single write port of the 32-entry integer register file between two writeback requesters: req0 (EXU/ALU result) and req1 (LSU load data).
- Keeps a per-register busy scoreboard. Issue reserves a destination register. The bit clears on the same clock edge that the register file commits the write.
- Issue logic queries the scoreboard for the two source registers to detect RAW hazards.
- Sits between the writeback sources and the register file's w_en/waddr/wdata inputs.

Parameters:
- ADDR_WIDTH, 5, register address width; the register count is 1<<ADDR_WIDTH.
- DATA_WIDTH, 32, register data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rstn  in  1  synchronous, active-low reset.
- req0_valid  in  1  EXU write request valid.
- req0_ready  out  1  EXU request accepted this cycle.
- req0_addr  in  ADDR_WIDTH  EXU destination register.
- req0_data  in  DATA_WIDTH  EXU write data.
- req1_valid  in  1  LSU write request valid.
- req1_ready  out  1  LSU request accepted this cycle.
- req1_addr  in  ADDR_WIDTH  LSU destination register.
- req1_data  in  DATA_WIDTH  LSU write data.
- rsv_valid  in  1  issue stage reserves a destination register.
- rsv_ready  out  1  reservation accepted.
- rsv_addr  in  ADDR_WIDTH  register to reserve.
- qa_addr  in  ADDR_WIDTH  source register A to query.
- qb_addr  in  ADDR_WIDTH  source register B to query.
- qa_busy  out  1  source A has a pending write.
- qb_busy  out  1  source B has a pending write.
- rf_w_en  out  1  register file write enable (registered).
- rf_waddr  out  ADDR_WIDTH  register file write address (registered).
- rf_wdata  out  DATA_WIDTH  register file write data (registered).

Behaviour:
- Reset (rstn=0 at posedge):
  - busy vector cleared to all zeros.
  - rf_w_en=0, rf_waddr=0, rf_wdata=0.
  - Round-robin pointer last_grant=1, so req0 has priority first.
  - Reset mid-operation discards any in-flight write: rf_w_en is 0 on the cycle after reset regardless of the prior grant.
- Arbitration is combinational, round-robin over the two requesters:
  - Only one valid: that requester is granted.
  - Both valid: the requester not equal to last_grant is granted.
  - last_grant updates on the clock edge ending a granted cycle.
  - reqN_ready = grant N. The register file cannot stall, so the arbiter never withholds a grant when any request is valid.
  - Ready never depends on the other requester's data. A requester must hold valid/addr/data until ready.
- Write pipeline, one register stage:
  - Request accepted in cycle T → rf_w_en/rf_waddr/rf_wdata valid during cycle T+1.
  - The register file commits at the edge ending T+1.
  - When no grant occurs, rf_w_en=0 the next cycle; rf_waddr and rf_wdata hold their previous values.
- Register x0:
  - A granted request with addr=0 is accepted (ready=1) but produces rf_w_en=0 in T+1.
  - Reservations of x0 have rsv_ready=1 and do not set any bit.
  - busy[0] is constant 0.
- Scoreboard:
  - Set: rsv_valid && rsv_ready && rsv_addr!=0 sets busy[rsv_addr] at the edge.
  - rsv_ready = !busy[rsv_addr]. A second reservation to a pending register stalls until the write commits.
  - Clear: rf_w_en=1 clears busy[rf_waddr] at the edge ending that cycle, coincident with the register file write.
  - Same-edge set and clear to the same address: set wins, so the bit stays 1. This cannot arise via rsv_ready alone; the rule is still required for robustness.
  - A clear to a register whose bit is already 0 has no effect and is not an error.
- Queries are combinational reads of the current busy vector: qa_busy = busy[qa_addr], qb_busy = busy[qb_addr].
  - No bypass of same-cycle clears. A register whose write commits at the end of this cycle still reads busy=1 this cycle.
- Width rules:
  - No arithmetic on data; data passes unmodified.
  - Addresses are compared at the full ADDR_WIDTH.

Test Plan:
- Reset then idle → rf_w_en=0, qa_busy=qb_busy=0 for all addresses, rsv_ready=1.
- rsv x5; next cycle req0 {addr=5, data=0xDEADBEEF} → req0_ready=1; next cycle rf_w_en=1, rf_waddr=5, rf_wdata=0xDEADBEEF; qa_addr=5 gives qa_busy=1 through that cycle and 0 the cycle after.
- req0 and req1 valid for 4 consecutive cycles (addrs 1/2, data 0x11/0x22) → grants alternate 0,1,0,1; rf_waddr sequence 1,2,1,2, each one cycle after its grant.
- rsv x7 twice back-to-back → second rsv_ready=0 until the write to x7 commits, then 1 on the following cycle.
- req1 {addr=0, data=0xFFFFFFFF} → req1_ready=1, rf_w_en stays 0; rsv x0 → rsv_ready=1 and qa_busy for x0 stays 0.
- Grant req0 {addr=3} in cycle T with rstn=0 at the edge ending T → rf_w_en=0 in T+1, busy[3]=0, and the next simultaneous request pair grants req0 first.
